// File: rtl/nes_bus_pkg.sv
// Shared types, address map constants and region decode for the NES CPU bus responder.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PPU,
    REG_DMA,
    REG_IO,
    REG_OPEN,
    REG_PRG
  } region_e;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

  localparam logic [15:0] RAM_END     = 16'h1FFF;
  localparam logic [15:0] PPU_END     = 16'h3FFF;
  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam logic [15:0] IO_END      = 16'h401F;
  localparam logic [15:0] PRG_BASE    = 16'h8000;
  localparam logic [2:0]  PPU_OAMDATA = 3'd4;

  function automatic region_e decode_region(input logic [15:0] addr);
    if (addr <= RAM_END)          return REG_RAM;
    else if (addr <= PPU_END)     return REG_PPU;
    else if (addr == OAMDMA_ADDR) return REG_DMA;
    else if (addr <= IO_END)      return REG_IO;
    else if (addr < PRG_BASE)     return REG_OPEN;
    else                          return REG_PRG;
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// $4014 OAM DMA engine: halts the CPU, then alternates a source read and a $2004 write 256 times.
module nes_oam_dma
  import nes_bus_pkg::*;
#(
  parameter int DMA_ALIGN_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_page,
  output logic        o_busy,
  output logic        o_bus_req,
  output logic [15:0] o_addr,
  output logic        o_ppu_we
);

  localparam bit ALIGN = (DMA_ALIGN_EN != 0);

  dma_state_e r_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic       r_parity;
  logic       r_busy;
  logic       r_rd;
  logic       r_wr;

  // Outputs are registered alongside the next state so they line up with it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DMA_IDLE;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_parity <= 1'b0;
      r_busy   <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      case (r_state)
        DMA_IDLE: if (i_start) begin
          r_page  <= i_page;
          r_idx   <= 8'h00;
          r_busy  <= 1'b1;
          r_state <= DMA_HALT;
        end
        DMA_HALT: if (ALIGN && r_parity) begin
          r_state <= DMA_ALIGN;
        end else begin
          r_state <= DMA_READ;
          r_rd    <= 1'b1;
        end
        DMA_ALIGN: begin
          r_state <= DMA_READ;
          r_rd    <= 1'b1;
        end
        DMA_READ: begin
          r_state <= DMA_WRITE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b1;
        end
        DMA_WRITE: begin
          r_wr  <= 1'b0;
          r_idx <= r_idx + 8'd1;
          if (r_idx == 8'hFF) begin
            r_state <= DMA_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DMA_READ;
            r_rd    <= 1'b1;
          end
        end
        default: begin
          r_state <= DMA_IDLE;
          r_busy  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_bus_req = r_rd;
  assign o_addr    = {r_page, r_idx};
  assign o_ppu_we  = r_wr;

endmodule

// File: rtl/nes_cpu_bus_responder.sv
// Memory-side responder for the 6502 bus: RAM, PPU registers, PRG ROM, open bus and OAM DMA.
module nes_cpu_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int RAM_AW       = 11,
  parameter int PRG_AW       = 15,
  parameter int DMA_ALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdy,
  output logic              ppu_sel,
  output logic [2:0]        ppu_reg,
  output logic              ppu_we,
  output logic [7:0]        ppu_wdata,
  input  logic [7:0]        ppu_rdata,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_rdata
);

  logic [7:0]  r_ram [0:(1<<RAM_AW)-1];
  logic [7:0]  r_ram_q;
  logic [7:0]  r_open;
  region_e     r_tag;
  logic        r_rd_valid;

  logic        w_dma_busy;
  logic        w_dma_req;
  logic        w_dma_we;
  logic [15:0] w_dma_addr;
  logic        w_cpu_act;
  logic        w_dma_rd;
  logic        w_dma_wr;
  logic [15:0] w_eff_addr;
  region_e     w_region;
  logic        w_rd_act;
  logic        w_wr_act;
  logic        w_dma_start;
  logic [7:0]  w_rdata;

  // The CPU bus is ignored whenever the DMA holds the CPU; rst masks every access.
  assign w_cpu_act   = ~rst & ~w_dma_busy;
  assign w_dma_rd    = ~rst & w_dma_req;
  assign w_dma_wr    = ~rst & w_dma_we;
  assign w_eff_addr  = w_dma_rd ? w_dma_addr : cpu_addr;
  assign w_region    = decode_region(w_eff_addr);
  assign w_rd_act    = w_dma_rd | (w_cpu_act & cpu_rw);
  assign w_wr_act    = w_cpu_act & ~cpu_rw;
  assign w_dma_start = w_wr_act && (w_region == REG_DMA);

  nes_oam_dma #(
    .DMA_ALIGN_EN(DMA_ALIGN_EN)
  ) u_dma (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_dma_start),
    .i_page   (cpu_wdata),
    .o_busy   (w_dma_busy),
    .o_bus_req(w_dma_req),
    .o_addr   (w_dma_addr),
    .o_ppu_we (w_dma_we)
  );

  // NOTE: the RAM array has no reset branch so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_act && (w_region == REG_RAM)) r_ram[w_eff_addr[RAM_AW-1:0]] <= cpu_wdata;
    if (w_rd_act && (w_region == REG_RAM)) r_ram_q <= r_ram[w_eff_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag      <= REG_OPEN;
      r_rd_valid <= 1'b0;
      r_open     <= 8'h00;
    end else begin
      r_tag      <= w_rd_act ? w_region : REG_OPEN;
      r_rd_valid <= w_rd_act;
      if (w_wr_act)        r_open <= cpu_wdata;
      else if (r_rd_valid) r_open <= w_rdata;
    end
  end

  always_comb begin
    case (r_tag)
      REG_RAM: w_rdata = r_ram_q;
      REG_PPU: w_rdata = ppu_rdata;
      REG_PRG: w_rdata = prg_rdata;
      default: w_rdata = r_open;
    endcase
  end

  assign cpu_rdata = rst ? 8'h00 : w_rdata;
  assign cpu_rdy   = rst | ~w_dma_busy;
  assign prg_addr  = (w_rd_act && (w_region == REG_PRG)) ? w_eff_addr[PRG_AW-1:0] : '0;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    ppu_sel   = 1'b0;
    ppu_we    = 1'b0;
    ppu_reg   = 3'd0;
    ppu_wdata = 8'h00;
    if (w_dma_wr) begin
      ppu_sel   = 1'b1;
      ppu_we    = 1'b1;
      ppu_reg   = PPU_OAMDATA;
      ppu_wdata = w_rdata;
    end else if ((w_region == REG_PPU) && (w_rd_act || w_wr_act)) begin
      ppu_sel = 1'b1;
      ppu_we  = w_wr_act;
      ppu_reg = w_eff_addr[2:0];
      if (w_wr_act) ppu_wdata = cpu_wdata;
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Directed scoreboard bench for nes_cpu_bus_responder: bus decode, open bus, OAM DMA and reset abort.
module tb_nes_cpu_bus_responder;

  localparam int ALIGN_EN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        ppu_sel;
  logic [2:0]  ppu_reg;
  logic        ppu_we;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata = 8'h00;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata = 8'h00;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr     = 0;
  logic        par      = 1'b0;
  logic [7:0]  rd_q[$];
  logic [7:0]  dma_q[$];
  logic        s_sel, s_we;
  logic [2:0]  s_reg;
  logic [14:0] s_prg;

  always #5 clk = ~clk;

  nes_cpu_bus_responder #(
    .RAM_AW(11), .PRG_AW(15), .DMA_ALIGN_EN(ALIGN_EN)
  ) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .ppu_sel(ppu_sel), .ppu_reg(ppu_reg),
    .ppu_we(ppu_we), .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
    .prg_addr(prg_addr), .prg_rdata(prg_rdata)
  );

  // Synchronous ROM with contents addr[7:0]^4C, PPU returning C0|reg, and a cycle-parity model.
  always @(posedge clk) prg_rdata <= prg_addr[7:0] ^ 8'h4C;
  always @(posedge clk) if (ppu_sel && !ppu_we) ppu_rdata <= 8'hC0 | {5'd0, ppu_reg};
  always @(posedge clk) par <= rst ? 1'b0 : ~par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ppu_sel && ppu_we && ppu_reg == 3'd4) begin
      n_wr++;
      if (dma_q.size() > 0) check("dma_byte", {24'd0, ppu_wdata}, {24'd0, dma_q.pop_front()});
      else                  check("dma_spurious_we", {31'd0, ppu_we}, 32'd0);
    end
  end

  task automatic idle_bus();
    cpu_addr  = 16'h5000;
    cpu_rw    = 1'b1;
    cpu_wdata = 8'h00;
  endtask

  task automatic snap();
    s_sel = ppu_sel;
    s_we  = ppu_we;
    s_reg = ppu_reg;
    s_prg = prg_addr;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rw = 1'b0; cpu_wdata = d;
    @(negedge clk); snap();
    @(posedge clk); #1; idle_bus();
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rw = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk); snap();
    @(posedge clk); #1; idle_bus();
    @(negedge clk); check(tag, {24'd0, cpu_rdata}, {24'd0, rd_q.pop_front()});
  endtask

  // Leaves the bench in a cycle of parity h, so the $4014 write that follows puts HALT on parity h.
  task automatic wait_parity(input logic h);
    @(posedge clk); #1;
    for (int k = 0; k < 4 && par != h; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_dma(input logic [7:0] page, input logic h);
    wait_parity(h);
    for (int i = 0; i < 256; i++) dma_q.push_back(i[7:0] ^ 8'h5A);
    n_wr = 0;
    bus_write(16'h4014, page);
    // Hostile CPU write while halted; it must be ignored.
    cpu_addr = 16'h0200; cpu_rw = 1'b0; cpu_wdata = 8'hFF;
  endtask

  task automatic finish_dma(input logic h);
    int len = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (cpu_rdy) break;
      len++;
    end
    idle_bus();
    check("dma_len", len, (ALIGN_EN != 0 && h) ? 514 : 513);
    check("dma_writes", n_wr, 256);
    check("dma_q_empty", dma_q.size(), 0);
    check("rdy_after_dma", {31'd0, cpu_rdy}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", {24'd0, cpu_rdata}, 32'h00);
    check("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    check("rst_ppu_sel", {31'd0, ppu_sel}, 32'd0);
    check("rst_ppu_we", {31'd0, ppu_we}, 32'd0);
    check("rst_ppu_reg", {29'd0, ppu_reg}, 32'd0);
    check("rst_ppu_wdata", {24'd0, ppu_wdata}, 32'd0);
    check("rst_prg_addr", {17'd0, prg_addr}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("open_after_rst", {24'd0, cpu_rdata}, 32'h00);

    bus_write(16'h0005, 8'hA5);
    bus_read("ram_mirror_1805", 16'h1805, 8'hA5);
    bus_write(16'h07FF, 8'h3C);
    bus_read("ram_mirror_1fff", 16'h1FFF, 8'h3C);

    bus_read("prg_8000", 16'h8000, 8'h4C);
    check("prg_addr_8000", {17'd0, s_prg}, 32'h0000);
    bus_write(16'h8000, 8'h11);
    bus_read("prg_after_write", 16'h8000, 8'h4C);
    bus_read("prg_fffc", 16'hFFFC, 8'hB0);
    check("prg_addr_fffc", {17'd0, s_prg}, 32'h7FFC);

    bus_write(16'h2003, 8'h00);
    check("ppu_wr_sel", {31'd0, s_sel}, 32'd1);
    check("ppu_wr_we", {31'd0, s_we}, 32'd1);
    check("ppu_wr_reg", {29'd0, s_reg}, 32'd3);
    @(negedge clk);
    check("ppu_wr_sel_1cyc", {31'd0, ppu_sel}, 32'd0);
    check("ppu_wr_we_1cyc", {31'd0, ppu_we}, 32'd0);
    bus_read("ppu_rd_3ffa", 16'h3FFA, 8'hC2);
    check("ppu_rd_sel", {31'd0, s_sel}, 32'd1);
    check("ppu_rd_we", {31'd0, s_we}, 32'd0);
    check("ppu_rd_reg", {29'd0, s_reg}, 32'd2);

    bus_write(16'h0210, 8'h77);
    bus_read("open_5000", 16'h5000, 8'h77);
    bus_read("open_4014", 16'h4014, 8'h77);
    bus_read("open_4016", 16'h4016, 8'h77);

    for (int i = 0; i < 256; i++) bus_write(16'h0200 + 16'(i), i[7:0] ^ 8'h5A);

    // HALT on even parity: no alignment stall.
    start_dma(8'h02, 1'b0);
    finish_dma(1'b0);
    bus_read("ram_after_dma", 16'h0200, 8'h5A);

    // HALT on odd parity: one alignment stall.
    start_dma(8'h02, 1'b1);
    finish_dma(1'b1);

    // Abort a DMA with rst after its 100th PPU write.
    start_dma(8'h02, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (n_wr >= 100) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    dma_q.delete();
    @(negedge clk);
    check("rdy_after_abort", {31'd0, cpu_rdy}, 32'd1);
    check("writes_at_abort", n_wr, 100);
    repeat (20) @(negedge clk);
    check("no_writes_after_abort", n_wr, 100);
    check("rdy_stays_high", {31'd0, cpu_rdy}, 32'd1);

    start_dma(8'h02, 1'b0);
    finish_dma(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
